// File: rtl/tile_write_arbiter_if.sv
// tile_write_arbiter_if: producer request bus and tile RAM write port of the tile write arbiter.
interface tile_write_arbiter_if #(
   parameter int NUM_CH = 6,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic                     enable;
   logic                     clear_req;
   logic [NUM_CH-1:0]        req;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*DATA_W-1:0] req_data;
   logic [NUM_CH-1:0]        ack;
   logic                     ram_wea;
   logic [ADDR_W-1:0]        ram_addr;
   logic [DATA_W-1:0]        ram_data;
   logic                     clearing;
   logic                     clear_done;
   logic                     drop_err;
   modport master (
      output enable, clear_req, req, req_addr, req_data,
      input  ack, ram_wea, ram_addr, ram_data, clearing, clear_done, drop_err
   );
   modport slave (
      input  enable, clear_req, req, req_addr, req_data,
      output ack, ram_wea, ram_addr, ram_data, clearing, clear_done, drop_err
   );
endinterface

// File: rtl/tile_write_arbiter.sv
// tile_write_arbiter: one-write-per-cycle scheduler of N tile producers onto the bg tile RAM,
// with a full-screen clear sweep that stalls all producers while it runs.
module tile_write_arbiter #(
   parameter int                NUM_CH     = 6,
   parameter int                ADDR_W     = 16,
   parameter int                DATA_W     = 32,
   parameter int                TILE_COLS  = 40,
   parameter int                TILE_ROWS  = 30,
   parameter logic [DATA_W-1:0] CLEAR_DATA = '0,
   parameter bit                FIXED_PRIO = 1'b0
) (
   input logic                i_clk,
   input logic                i_reset,
   tile_write_arbiter_if.slave bus
);
   localparam int TILES = TILE_COLS * TILE_ROWS;
   localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(TILES);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TILES - 1);

   if (longint'(TILES) >= (longint'(1) << ADDR_W)) begin : g_size_check
      $error("tile_write_arbiter: TILE_COLS*TILE_ROWS does not fit in ADDR_W bits");
   end

   typedef enum logic {ARB, CLEAR} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [PW-1:0]     r_last;
   logic              r_pend;
   logic              r_wea;
   logic              r_done;
   logic              r_drop;
   logic [PW-1:0]     w_win;
   logic              w_found;
   logic              w_clr_go;
   logic              w_grant;
   logic              w_in_range;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;

   // Candidate order: plain index for fixed priority, rotated past the last winner for round-robin.
   function automatic logic [PW-1:0] slot(input int k, input logic [PW-1:0] last);
      return PW'(FIXED_PRIO ? k : (int'(last) + 1 + k) % NUM_CH);
   endfunction

   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!w_found && bus.req[slot(k, r_last)]) begin
            w_found = 1'b1;
            w_win   = slot(k, r_last);
         end
      end
   end

   assign w_clr_go   = bus.clear_req | r_pend;
   assign w_grant    = i_reset & bus.enable & (r_state == ARB) & ~w_clr_go & w_found;
   assign w_addr     = bus.req_addr[int'(w_win) * ADDR_W +: ADDR_W];
   assign w_data     = bus.req_data[int'(w_win) * DATA_W +: DATA_W];
   assign w_in_range = w_addr < LIMIT;

   assign bus.ack        = w_grant ? NUM_CH'(1) << w_win : '0;
   assign bus.ram_wea    = r_wea;
   assign bus.ram_addr   = r_addr;
   assign bus.ram_data   = r_data;
   assign bus.clearing   = r_state == CLEAR;
   assign bus.clear_done = r_done;
   assign bus.drop_err   = r_drop;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ARB;
         r_ptr   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_last  <= PW'(NUM_CH - 1);
         r_pend  <= 1'b0;
         r_wea   <= 1'b0;
         r_done  <= 1'b0;
         r_drop  <= 1'b0;
      end else if (!bus.enable) begin
         r_wea  <= 1'b0;
         r_done <= 1'b0;
         r_pend <= r_pend | bus.clear_req;
      end else if (r_state == ARB) begin
         r_done <= 1'b0;
         r_wea  <= w_grant & w_in_range;
         if (w_clr_go) begin
            r_state <= CLEAR;
            r_pend  <= 1'b0;
         end
         if (w_grant) begin
            r_last <= w_win;
            r_drop <= r_drop | ~w_in_range;
         end
         if (w_grant && w_in_range) begin
            r_addr <= w_addr;
            r_data <= w_data;
         end
      end else begin
         r_wea  <= 1'b1;
         r_addr <= r_ptr;
         r_data <= CLEAR_DATA;
         r_done <= r_ptr == LAST;
         r_ptr  <= r_ptr == LAST ? '0 : r_ptr + 1'b1;
         // A clear requested during the sweep restarts it from tile 0 without leaving CLEAR.
         r_state <= (r_ptr == LAST && !(r_pend || bus.clear_req)) ? ARB : CLEAR;
         r_pend  <= r_ptr == LAST ? 1'b0 : r_pend | bus.clear_req;
      end
   end
endmodule

// File: tb/tb_tile_write_arbiter.sv
// tb_tile_write_arbiter: random and directed stimulus on a round-robin and a fixed-priority
// arbiter, both checked every cycle against a behavioural model plus literal expectations.
module tb_tile_write_arbiter;
   localparam int N = 6, AW = 16, DW = 32, TILES = 1200;

   logic clk = 0, rst = 0, en = 0, clr = 0;
   logic [N-1:0] req = '0;
   logic [AW-1:0] addr [N];
   logic [DW-1:0] data [N];
   logic [N*AW-1:0] pa;
   logic [N*DW-1:0] pd;
   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   always_comb begin
      pa = '0;
      pd = '0;
      for (int k = 0; k < N; k++) begin
         pa[k*AW +: AW] = addr[k];
         pd[k*DW +: DW] = data[k];
      end
   end

   tile_write_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) if0 ();
   tile_write_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) if1 ();

   assign if0.enable = en;  assign if0.clear_req = clr;  assign if0.req = req;
   assign if0.req_addr = pa; assign if0.req_data = pd;
   assign if1.enable = en;  assign if1.clear_req = clr;  assign if1.req = req;
   assign if1.req_addr = pa; assign if1.req_data = pd;

   tile_write_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0))
      u_rr (.i_clk(clk), .i_reset(rst), .bus(if0.slave));
   tile_write_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1))
      u_fp (.i_clk(clk), .i_reset(rst), .bus(if1.slave));

   logic [N-1:0]  o_ack [2];
   logic          o_wea [2], o_clearing [2], o_done [2], o_drop [2];
   logic [AW-1:0] o_addr [2];
   logic [DW-1:0] o_data [2];
   assign o_ack[0] = if0.ack;           assign o_ack[1] = if1.ack;
   assign o_wea[0] = if0.ram_wea;       assign o_wea[1] = if1.ram_wea;
   assign o_addr[0] = if0.ram_addr;     assign o_addr[1] = if1.ram_addr;
   assign o_data[0] = if0.ram_data;     assign o_data[1] = if1.ram_data;
   assign o_clearing[0] = if0.clearing; assign o_clearing[1] = if1.clearing;
   assign o_done[0] = if0.clear_done;   assign o_done[1] = if1.clear_done;
   assign o_drop[0] = if0.drop_err;     assign o_drop[1] = if1.drop_err;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: a clear is a count of tiles still to sweep; d=0 round-robin, d=1 fixed.
   int            m_left [2];
   bit            m_pend [2];
   int            m_last [2];
   bit            e_wea [2], e_done [2], e_drop [2];
   logic [AW-1:0] e_addr [2];
   logic [DW-1:0] e_data [2];
   int            mw;
   logic [N-1:0]  ma;

   function automatic int winner(input int d, input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         int c;
         c = (d == 1) ? k : (m_last[d] + 1 + k) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         mw = -1;
         if (!rst) begin
            m_left[d] = 0; m_pend[d] = 0; m_last[d] = N - 1;
            e_wea[d] = 0; e_done[d] = 0; e_drop[d] = 0; e_addr[d] = '0; e_data[d] = '0;
         end else if (en && m_left[d] == 0 && !(clr || m_pend[d]) && req != 0) begin
            mw = winner(d, req);
         end
         ma = (mw < 0) ? '0 : N'(1) << mw;
         chk(d ? "m_fp_ack" : "m_rr_ack", o_ack[d], ma);
         chk(d ? "m_fp_wea" : "m_rr_wea", o_wea[d], e_wea[d]);
         chk(d ? "m_fp_addr" : "m_rr_addr", o_addr[d], e_addr[d]);
         chk(d ? "m_fp_data" : "m_rr_data", o_data[d], e_data[d]);
         chk(d ? "m_fp_done" : "m_rr_done", o_done[d], e_done[d]);
         chk(d ? "m_fp_drop" : "m_rr_drop", o_drop[d], e_drop[d]);
         chk(d ? "m_fp_clearing" : "m_rr_clearing", o_clearing[d], m_left[d] != 0);
         if (rst) begin
            if (!en) begin
               e_wea[d] = 0; e_done[d] = 0; m_pend[d] = m_pend[d] | clr;
            end else if (m_left[d] == 0) begin
               e_done[d] = 0; e_wea[d] = 0;
               if (clr || m_pend[d]) begin
                  m_left[d] = TILES; m_pend[d] = 0;
               end else if (mw >= 0) begin
                  if (addr[mw] < TILES) begin
                     e_wea[d] = 1; e_addr[d] = addr[mw]; e_data[d] = data[mw];
                  end else e_drop[d] = 1;
                  m_last[d] = mw;
               end
            end else begin
               e_wea[d] = 1; e_addr[d] = AW'(TILES - m_left[d]); e_data[d] = '0;
               m_left[d]--;
               e_done[d] = m_left[d] == 0;
               if (m_left[d] == 0) begin
                  if (m_pend[d] || clr) m_left[d] = TILES;
                  m_pend[d] = 0;
               end else m_pend[d] = m_pend[d] | clr;
            end
         end
      end
   end

   int cnt [N];
   int seq [3] = '{1, 2, 5};
   int n_a, n_b, n_c;

   initial begin
      for (int k = 0; k < N; k++) begin addr[k] = AW'(k * 7); data[k] = '0; cnt[k] = 0; end
      repeat (2) step;
      rst = 1; en = 1;
      #1;
      chk("rst_ack", o_ack[0], 0); chk("rst_wea", o_wea[0], 0);
      chk("rst_drop", o_drop[0], 0); chk("rst_clearing", o_clearing[0], 0);
      // single channel
      req = 6'b000100; addr[2] = 16'd1081; data[2] = 32'h1C6;
      #1;
      chk("single_ack_rr", o_ack[0], 6'b000100); chk("single_ack_fp", o_ack[1], 6'b000100);
      step; req = '0;
      chk("single_wea", o_wea[0], 1); chk("single_addr", o_addr[0], 1081); chk("single_data", o_data[0], 32'h1C6);
      // round-robin fairness from a fresh reset
      rst = 0; step; rst = 1;
      req = '1;
      for (int k = 0; k < N; k++) begin addr[k] = AW'(100 + k); data[k] = DW'(k); end
      for (int c = 0; c < 12; c++) begin
         #1;
         chk("rr_ack", o_ack[0], N'(1) << (c % N));
         chk("fp_all_ack", o_ack[1], 6'b000001);
         for (int k = 0; k < N; k++) if (o_ack[0][k]) cnt[k]++;
         step;
      end
      for (int k = 0; k < N; k++) chk("rr_count", cnt[k], 2);
      // fixed priority starvation
      req = 6'b100110; n_a = 0;
      for (int c = 0; c < 9; c++) begin
         #1;
         chk("fp_ack", o_ack[1], 6'b000010);
         chk("rr_mix_ack", o_ack[0], N'(1) << seq[c % 3]);
         if (o_ack[1][2] || o_ack[1][5]) n_a++;
         step;
      end
      chk("fp_starve", n_a, 0);
      // full clear with a waiting producer
      req = 6'b000001; clr = 1;
      #1 chk("clr_noack", o_ack[0], 0);
      step; clr = 0;
      n_a = 0; n_b = 0; n_c = 0;
      for (int k = 0; k < TILES; k++) begin
         #1 if (o_ack[0] != 0) n_c++;
         step;
         if (o_wea[0] && o_addr[0] == AW'(k) && o_data[0] == 0) n_a++;
         if (o_done[0]) begin n_b++; chk("clr_done_addr", o_addr[0], 1199); end
      end
      chk("clr_noack_cnt", n_c, 0); chk("clr_writes", n_a, TILES); chk("clr_done_cnt", n_b, 1);
      chk("clr_end_clearing", o_clearing[0], 0);
      #1 chk("clr_after_ack", o_ack[0], 6'b000001);
      step;
      // clear re-trigger mid sweep
      clr = 1; step;
      n_a = 0; n_b = 0;
      for (int k = 0; k < 2 * TILES; k++) begin
         clr = (k == 500);
         step;
         if (o_wea[0] && o_addr[0] == AW'(k % TILES)) n_a++;
         if (o_done[0]) n_b++;
      end
      clr = 0;
      chk("retrig_writes", n_a, 2 * TILES); chk("retrig_done", n_b, 2);
      #1 chk("retrig_after_ack", o_ack[0], 6'b000001);
      // clear request latched while disabled
      en = 0; clr = 1;
      #1 chk("en0_ack", o_ack[0], 0);
      step; clr = 0;
      repeat (3) step;
      chk("en0_wea", o_wea[0], 0); chk("en0_clearing", o_clearing[0], 0);
      en = 1;
      #1 chk("pend_noack", o_ack[0], 0);
      n_b = 0;
      for (int k = 0; k < TILES + 1; k++) begin step; if (o_done[0]) n_b++; end
      chk("pend_done", n_b, 1);
      #1 chk("pend_after_ack", o_ack[0], 6'b000001);
      // out-of-range drop
      req = 6'b001000; addr[3] = 16'd1200;
      #1 chk("oor_ack", o_ack[0], 6'b001000);
      step; req = '0;
      chk("oor_wea", o_wea[0], 0); chk("oor_drop", o_drop[0], 1);
      repeat (5) step;
      chk("oor_drop_sticky", o_drop[1], 1);
      // randomized traffic, checked by the model
      for (int c = 0; c < 4000; c++) begin
         en = $urandom_range(0, 9) != 0;
         clr = $urandom_range(0, 1499) == 0;
         req = N'($urandom);
         for (int k = 0; k < N; k++) begin
            addr[k] = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(1200, 1300)) : AW'($urandom_range(0, 1199));
            data[k] = $urandom;
         end
         step;
      end
      // asynchronous reset in the middle of a clear
      en = 1; req = '0; clr = 1; step; clr = 0;
      repeat (100) step;
      chk("mid_clearing", o_clearing[0], 1);
      req = 6'b000001; rst = 0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("arst_ack", o_ack[d], 0); chk("arst_wea", o_wea[d], 0); chk("arst_addr", o_addr[d], 0);
         chk("arst_data", o_data[d], 0); chk("arst_clearing", o_clearing[d], 0);
         chk("arst_done", o_done[d], 0); chk("arst_drop", o_drop[d], 0);
      end
      step; rst = 1;
      #1 chk("post_rst_ack", o_ack[0], 6'b000001);
      step; step;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/tile_write_arbiter.md
Name: tile_write_arbiter

Overview:
- Parametrised N-channel write scheduler for the background tile RAM. Replaces the fixed counter-sliced address/data multiplexer in the game engine.
- Each tile producer (floor, score, coin, ghost, text, ...) issues single-word write requests through a req/ack handshake.
- Writes are granted one per cycle by round-robin or fixed priority. A full-screen clear mode stalls all channels while it runs.
- Sits between the game-logic producers and the port-A write side of the bg tile RAM.

Parameters:
- NUM_CH, 6, number of requesting channels (1..16).
- ADDR_W, 16, tile RAM address width.
- DATA_W, 32, tile RAM data width.
- TILE_COLS, 40, tiles per row.
- TILE_ROWS, 30, tile rows. The legal address range is 0..TILE_COLS*TILE_ROWS-1.
- CLEAR_DATA, 0, word written to every tile during a clear.
- FIXED_PRIO, 0, arbitration mode:
  - 0 = round-robin.
  - 1 = fixed priority, lowest channel index wins.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  arbitration enable (game_on). When low: no grants, no clear progress, state held.
- clear_req  in  1  single-cycle pulse requesting a full-screen clear.
- req  in  NUM_CH  per-channel write request; level, held until ack.
- req_addr  in  NUM_CH*ADDR_W  per-channel address; channel k occupies bits [k*ADDR_W +: ADDR_W].
- req_data  in  NUM_CH*DATA_W  per-channel data, packed the same way.
- ack  out  NUM_CH  one-hot, single-cycle grant.
- ram_wea  out  1  registered RAM write enable.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_data  out  DATA_W  registered RAM data.
- clearing  out  1  high while in CLEAR state.
- clear_done  out  1  one-cycle pulse on the cycle the last clear write is issued.
- drop_err  out  1  sticky flag: an out-of-range request was dropped. Cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous) drives these values:
  - ack=0, ram_wea=0, ram_addr=0, ram_data=0.
  - clearing=0, clear_done=0, drop_err=0.
  - state=ARB, clear pointer=0, clear_pending=0.
  - Round-robin last-grant pointer = NUM_CH-1, so channel 0 is served first.
  - Reset mid-clear aborts the clear; no resume.
- States:
  - ARB: arbitrate among asserted req bits.
  - CLEAR: sweep addresses.
- ARB, per cycle with enable=1:
  - If any req is asserted, pick one winner:
    - Round-robin: first asserted index searching upward from last+1, wrapping modulo NUM_CH; the pointer then becomes the winner.
    - Fixed priority: lowest asserted index; the pointer is unused.
  - ack[winner]=1 in the same cycle (combinational from req and state).
  - The next cycle registers ram_wea=1, ram_addr=req_addr[winner], ram_data=req_data[winner]. Write latency is 1 cycle after ack.
  - If no req is asserted, the next cycle has ram_wea=0; ram_addr and ram_data hold.
- Handshake rules:
  - A producer holds addr and data stable while req=1 and before ack.
  - Each ack consumes exactly one write.
  - Keeping req high after ack requests another write. It is eligible in the very next cycle and gets back-to-back writes only if no other channel competes (round-robin) or it has the lowest index (fixed).
- Out-of-range request (req_addr >= TILE_COLS*TILE_ROWS):
  - Still acked; next cycle ram_wea=0.
  - drop_err set to 1.
  - Round-robin pointer advances as for a normal grant.
- clear_req while in ARB:
  - The next state is CLEAR. No ack is given in the cycle clear_req is sampled.
  - Pending channel requests simply wait.
- CLEAR, per cycle with enable=1:
  - Issues ram_wea=1, ram_addr=pointer, ram_data=CLEAR_DATA, then increments the pointer.
  - After address TILE_COLS*TILE_ROWS-1 has been issued: pulse clear_done in that same cycle, reset the pointer to 0, return to ARB.
  - A full clear is exactly TILE_COLS*TILE_ROWS cycles. No address beyond the last tile is ever written.
- clear_req arriving during CLEAR:
  - Sets clear_pending; repeated pulses collapse to one.
  - At completion, if clear_pending=1: clear it, stay in CLEAR, restart from 0. clear_done still pulses for the first sweep.
- enable=0:
  - ack=0, ram_wea=0 next cycle, pointers and state frozen.
  - A clear_req pulse while enable=0 is still latched into clear_pending and is serviced once enable returns.
- Width rules:
  - Address compare uses ADDR_W bits against the product constant. The product must be < 2^ADDR_W; this is checked at elaboration.
  - The clear pointer is ADDR_W wide.
- Packed channel slices use the +: indexing convention stated under Ports.

Test Plan:
- Reset then single channel: req=6'b000100, req_addr[2]=1081, data=0x1C6 → ack=6'b000100 in cycle 0; cycle 1 ram_wea=1, ram_addr=1081, ram_data=0x1C6.
- Round-robin fairness, FIXED_PRIO=0: req=6'b111111 held 12 cycles → ack sequence ch0,1,2,3,4,5,0,1,..., each channel acked exactly twice.
- Fixed priority, FIXED_PRIO=1: req=6'b100110 held → ack=ch1 every cycle; ch2 and ch5 never acked while ch1 holds.
- Clear: clear_req pulse with req=6'b000001 held → no ack for 1200 cycles; addresses 0..1199 written with 0; clear_done pulses with ram_addr=1199 on the following cycle; ch0 acked on the first ARB cycle after.
- Clear re-trigger: clear_req at clear cycle 500 → second full sweep of 1200 writes follows immediately; total 2400 consecutive ram_wea=1 cycles.
- Out-of-range plus async reset: req_addr[3]=1200 → acked, ram_wea=0, drop_err=1 and stays 1; assert reset mid-CLEAR → all outputs 0 immediately, state ARB.
